// File: rtl/forward_scoreboard.sv
// Forwarding / hazard scoreboard for a short in-order pipeline.
//
// Tracks the destinations of the last DEPTH instructions that left EX
// (entry 0 = MEM, entry DEPTH-1 = oldest) and, for the instruction currently
// in EX, produces per-source bypass selects and a stall request.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   forward_en            1 = forwarding mode, 0 = stall-only mode
//   freeze                hold all tracked entries (SRAM wait)
//   flush                 clear all tracked entries on the edge
//   issue_valid           an instruction occupies EX this cycle
//   issue_wb_en           EX instruction writes a register
//   issue_is_load         EX instruction is a load
//   issue_dest            EX instruction destination register
//   src                   packed EX source addresses, field i = [i*REG_AW +: REG_AW]
//   src_used              bit i set when source i is read
//   sel                   packed selects, 0 = register file, k = entry k-1
//   stall                 hazard that forwarding cannot resolve
//   stall_count           saturating count of non-frozen stall cycles
module forward_scoreboard #(
  parameter int unsigned REG_AW  = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned SEL_W  = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       forward_en,
  input  logic                       freeze,
  input  logic                       flush,
  input  logic                       issue_valid,
  input  logic                       issue_wb_en,
  input  logic                       issue_is_load,
  input  logic [REG_AW-1:0]          issue_dest,
  input  logic [NUM_SRC*REG_AW-1:0]  src,
  input  logic [NUM_SRC-1:0]         src_used,
  output logic [NUM_SRC*SEL_W-1:0]   sel,
  output logic                       stall,
  output logic [15:0]                stall_count
);

  logic [DEPTH-1:0]             ent_valid_q;
  logic [DEPTH-1:0]             ent_wb_en_q;
  logic [DEPTH-1:0]             ent_is_load_q;
  logic [DEPTH-1:0][REG_AW-1:0] ent_dest_q;

  logic [NUM_SRC-1:0][DEPTH-1:0] hit;
  logic                          any_hit;
  logic                          load_use;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        hit[i][k] = ent_valid_q[k] & ent_wb_en_q[k] & src_used[i] &
                    (ent_dest_q[k] == src[i*REG_AW +: REG_AW]);
      end
    end
  end

  always_comb begin
    sel      = '0;
    any_hit  = 1'b0;
    load_use = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // Walk oldest to youngest so the youngest producer overwrites the select.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (hit[i][k]) begin
          any_hit = 1'b1;
          if (forward_en) begin
            sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end
        end
      end
      // A load still in MEM has no data to bypass yet.
      if (hit[i][0] && ent_is_load_q[0]) begin
        load_use = 1'b1;
      end
    end
    stall = issue_valid & (forward_en ? load_use : any_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_q   <= '0;
      ent_wb_en_q   <= '0;
      ent_is_load_q <= '0;
      ent_dest_q    <= '0;
    end else if (flush) begin
      ent_valid_q <= '0;
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_valid_q[k]   <= ent_valid_q[k-1];
        ent_wb_en_q[k]   <= ent_wb_en_q[k-1];
        ent_is_load_q[k] <= ent_is_load_q[k-1];
        ent_dest_q[k]    <= ent_dest_q[k-1];
      end
      // A stalled instruction stays in EX; a bubble goes down the pipe instead.
      ent_valid_q[0]   <= issue_valid & ~stall;
      ent_wb_en_q[0]   <= issue_wb_en;
      ent_is_load_q[0] <= issue_is_load;
      ent_dest_q[0]    <= issue_dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !freeze && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Parameters
REQ-001 The block SHALL have parameter REG_AW, default 4, meaning the register address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning the number of source operands checked per instruction.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning the number of tracked in-flight stages (entry 0 = MEM, entry DEPTH-1 = oldest).
REQ-004 The block SHALL have derived localparam SEL_W = clog2(DEPTH+1), meaning the width of one select field.

Interface
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 forward_en  in  1  1 = forwarding mode, 0 = stall-only mode.
REQ-008 freeze  in  1  pipeline hold during an SRAM wait.
REQ-009 flush  in  1  synchronous clear of all tracked entries.
REQ-010 issue_valid  in  1  an instruction is in EX this cycle.
REQ-011 issue_wb_en, issue_is_load  in  1 each  writeback enable and load flag of the EX instruction.
REQ-012 issue_dest  in  REG_AW  destination of the EX instruction.
REQ-013 src  in  NUM_SRC*REG_AW  packed source addresses of the EX instruction; field i = bits [i*REG_AW +: REG_AW].
REQ-014 src_used  in  NUM_SRC  bit i = 1 when source i is read.
REQ-015 sel  out  NUM_SRC*SEL_W  packed selects; field value 0 = register file, k = entry k-1.
REQ-016 stall  out  1  hazard not resolvable by forwarding.
REQ-017 stall_count  out  16  saturating count of stall cycles.

Function
REQ-018 The block SHALL hold DEPTH entries, each {valid, wb_en, is_load, dest}.
REQ-019 With freeze=0 and flush=0, on each edge entry[k] SHALL load entry[k-1] for k≥1.
REQ-020 Under the same condition, entry[0] SHALL load the issue fields, with valid = issue_valid & ~stall, so a stall inserts a bubble.
REQ-021 With freeze=1 and flush=0, all entries SHALL hold their values.
REQ-022 With flush=1, all valid bits SHALL clear on the edge, regardless of freeze.
REQ-023 An entry matches source i when valid & wb_en & src_used[i] & dest == src field i.
REQ-024 sel and stall SHALL be combinational from the current entries and inputs, giving zero-cycle latency.
REQ-025 With forward_en=1, sel field i SHALL equal k+1 for the lowest-index matching entry k, else 0, so the youngest producer wins.
REQ-026 With forward_en=1, stall SHALL be 1 iff issue_valid and entry[0] matches some used source and entry[0].is_load=1 (load-use).
REQ-027 With forward_en=0, all sel fields SHALL be 0.
REQ-028 With forward_en=0, stall SHALL be 1 iff issue_valid and any entry matches any used source.
REQ-029 While freeze=1, sel and stall SHALL continue to reflect the held entries.
REQ-030 stall_count SHALL increment on each edge where stall=1 and freeze=0.
REQ-031 stall_count SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-032 A load-use stall SHALL last exactly one cycle in forwarding mode: the bubble moves the load to entry[1] and the select becomes 2.

Reset
REQ-033 While rst_n=0, all entry valid bits SHALL be 0 and stall_count SHALL be 0, immediately and without a clock.
REQ-034 Consequently, while rst_n=0 all sel fields SHALL read 0 and stall SHALL read 0.
REQ-035 Assertion of rst_n mid-stall or mid-freeze SHALL discard all tracked state.
REQ-036 The first edge after rst_n rises SHALL behave as a normal update.

Verification
REQ-037 Forwarding from MEM: issue ADD dest=3, then next instruction src0=3, forward_en=1 -> sel field0=1, stall=0.
REQ-038 Youngest wins: consecutive writers to r5 in entry[1] and entry[0], consumer src1=5 -> sel field1=1, not 2.
REQ-039 Load-use: LDR dest=2 in entry[0], consumer src0=2 -> stall=1 for one cycle, entry[0] becomes a bubble, next cycle sel field0=2, stall=0, stall_count=1.
REQ-040 Stall-only mode: forward_en=0, writer dest=7 in entry[1], consumer src0=7 -> sel=0, stall=1 until the writer leaves entry[DEPTH-1].
REQ-041 Freeze and flush: freeze=1 for 3 cycles with a match -> entries and sel held; flush=1 together with freeze=1 -> all valid bits 0 next cycle, sel=0.
REQ-042 Reset and saturation: drive rst_n=0 asynchronously mid-stall -> stall_count=0 and stall=0 at once; force 65536 stall cycles -> stall_count stays 16'hFFFF.
